// File: rtl/matrix_mult_stream_if.sv
// Operand/result handshake bundle for matrix_mult_stream.
// slave = the multiplier; master = the fetch/writeback side driving it.
interface matrix_mult_stream_if #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 40
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [N-1:0][N-1:0][WIDTH-1:0]         a_in;
  logic [N-1:0][N-1:0][WIDTH-1:0]         b_in;
  logic                                   in_signed;
  logic                                   in_acc;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [N-1:0][N-1:0][OUT_WIDTH-1:0]     c_out;
  logic                                   out_ovf;
  logic                                   busy;

  modport slave (
    input  in_valid, a_in, b_in, in_signed, in_acc, out_ready,
    output in_ready, out_valid, c_out, out_ovf, busy
  );

  modport master (
    output in_valid, a_in, b_in, in_signed, in_acc, out_ready,
    input  in_ready, out_valid, c_out, out_ovf, busy
  );
endinterface

// File: rtl/matrix_mult_stream.sv
// Streaming NxN matrix multiplier, one op per cycle, with in-place accumulation
// in the output register and sticky overflow reporting.
module matrix_mult_stream #(
  parameter int N          = 4,
  parameter int WIDTH      = 16,
  parameter int MUL_STAGES = 3,
  parameter int OUT_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_mult_stream_if.slave   bus
);

  localparam int PW = 2 * WIDTH;

  if (N < 2) begin : g_bad_n
    $error("matrix_mult_stream: N must be >= 2");
  end
  if (MUL_STAGES < 1) begin : g_bad_ms
    $error("matrix_mult_stream: MUL_STAGES must be >= 1");
  end
  if (OUT_WIDTH < 2 * WIDTH + $clog2(N)) begin : g_bad_ow
    $error("matrix_mult_stream: OUT_WIDTH must be >= 2*WIDTH + clog2(N)");
  end

  // Index 0..MUL_STAGES-1 are the product stages, MUL_STAGES is the sum stage.
  logic [MUL_STAGES:0]                 v_q;
  logic [MUL_STAGES:0]                 s_q;
  logic [MUL_STAGES:0]                 a_q;

  logic                                adv;
  logic                                out_valid_q;
  logic                                ovf_q;
  logic [N-1:0][N-1:0][OUT_WIDTH-1:0]  c_q;

  logic [PW-1:0]        prod_d [N][N][N];
  logic [PW-1:0]        prod_q [MUL_STAGES][N][N][N];
  logic [OUT_WIDTH-1:0] ext_d  [N][N][N];
  logic [OUT_WIDTH-1:0] sum_d  [N][N];
  logic [OUT_WIDTH-1:0] sum_q  [N][N];
  logic [OUT_WIDTH-1:0] acc_d  [N][N];
  logic [N*N-1:0]       elem_ovf;

  assign adv          = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.c_out    = c_q;
  assign bus.out_ovf  = ovf_q;
  assign bus.busy     = out_valid_q | (|v_q);

  // Operands are extended to 2*WIDTH so a single unsigned multiply yields the
  // correct low 2*WIDTH product bits for both signed and unsigned ops.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      for (genvar k = 0; k < N; k++) begin : g_k
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        logic [PW-1:0] pl;

        assign ax = {{WIDTH{bus.in_signed & bus.a_in[i][k][WIDTH-1]}}, bus.a_in[i][k]};
        assign bx = {{WIDTH{bus.in_signed & bus.b_in[k][j][WIDTH-1]}}, bus.b_in[k][j]};
        assign prod_d[i][j][k] = ax * bx;

        assign pl = prod_q[MUL_STAGES-1][i][j][k];
        assign ext_d[i][j][k] = {{(OUT_WIDTH-PW){s_q[MUL_STAGES-1] & pl[PW-1]}}, pl};
      end

      logic [OUT_WIDTH:0] wide;
      logic               sovf;

      assign wide          = {1'b0, c_q[i][j]} + {1'b0, sum_q[i][j]};
      assign acc_d[i][j]   = wide[OUT_WIDTH-1:0];
      assign sovf          = (c_q[i][j][OUT_WIDTH-1] == sum_q[i][j][OUT_WIDTH-1]) &&
                             (wide[OUT_WIDTH-1] != c_q[i][j][OUT_WIDTH-1]);
      assign elem_ovf[i*N+j] = s_q[MUL_STAGES] ? sovf : wide[OUT_WIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_d[i][j] = '0;
        for (int k = 0; k < N; k++) begin
          sum_d[i][j] = sum_d[i][j] + ext_d[i][j][k];
        end
      end
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q[0] <= prod_d;
      for (int s = 1; s < MUL_STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
      end
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      s_q         <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      c_q         <= '0;
    end else if (adv) begin
      v_q <= {v_q[MUL_STAGES-1:0], bus.in_valid};
      s_q <= {s_q[MUL_STAGES-1:0], bus.in_signed};
      a_q <= {a_q[MUL_STAGES-1:0], bus.in_acc};

      if (v_q[MUL_STAGES]) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            c_q[i][j] <= a_q[MUL_STAGES] ? acc_d[i][j] : sum_q[i][j];
          end
        end
        ovf_q       <= a_q[MUL_STAGES] ? (ovf_q | (|elem_ovf)) : 1'b0;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed bench for matrix_mult_stream with a reference-model scoreboard.
module tb_matrix_mult_stream;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MS = 3;
  localparam int OW = 40;

  localparam longint UMOD = 64'sd1 <<< OW;
  localparam longint SMAX = (64'sd1 <<< (OW-1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (OW-1));

  typedef logic [N-1:0][N-1:0][W-1:0]  amat_t;
  typedef logic [N-1:0][N-1:0][OW-1:0] cmat_t;
  typedef struct {
    cmat_t c;
    logic  ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_mult_stream_if #(.N(N), .WIDTH(W), .OUT_WIDTH(OW)) bus ();

  matrix_mult_stream #(.N(N), .WIDTH(W), .MUL_STAGES(MS), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t           sb[$];
  int             pop_cyc[$];
  logic [OW-1:0]  pop_val[$];
  exp_t           mon_e;

  cmat_t model_c;
  logic  model_ovf;
  amat_t pa, pb;
  bit    ps, pacc;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_mat(string tag, cmat_t got, cmat_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic amat_t fill(logic [W-1:0] v);
    amat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic amat_t ident();
    amat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = (i == j) ? W'(1) : W'(0);
    return m;
  endfunction

  function automatic longint prodv(logic [W-1:0] a, logic [W-1:0] b, bit s);
    if (s) return longint'($signed(a)) * longint'($signed(b));
    else   return longint'(a) * longint'(b);
  endfunction

  // Reference model: exact 64-bit arithmetic, range-checked against OUT_WIDTH.
  task automatic accept_op();
    cmat_t  nc;
    logic   any = 1'b0;
    longint e, prev, ex;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e = 0;
        for (int k = 0; k < N; k++) e += prodv(pa[i][k], pb[k][j], ps);
        if (pacc) begin
          prev = ps ? longint'($signed(model_c[i][j])) : longint'(model_c[i][j]);
          ex   = prev + e;
          if (ps) begin
            if (ex > SMAX || ex < SMIN) any = 1'b1;
          end else if (ex >= UMOD) begin
            any = 1'b1;
          end
        end else begin
          ex = e;
        end
        nc[i][j] = ex[OW-1:0];
      end
    end
    model_ovf = pacc ? (model_ovf | any) : 1'b0;
    model_c   = nc;
    sb.push_back('{nc, model_ovf});
  endtask

  task automatic drive_op(amat_t a, amat_t b, bit s, bit acc);
    pa = a; pb = b; ps = s; pacc = acc;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.in_signed = s;
    bus.in_acc    = acc;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    int t = 0;
    bit ok = 1'b0;
    while (t < 100) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    if (ok) begin
      accept_op();
      @(posedge clk);
      #1;
    end else begin
      chk("accept_timeout_in_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send(amat_t a, amat_t b, bit s, bit acc);
    drive_op(a, b, s, acc);
    wait_accept();
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_busy", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_output: observed extra result %h expected none", bus.c_out);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk_mat("c_out", bus.c_out, mon_e.c);
        chk("out_ovf", bus.out_ovf, mon_e.ovf);
      end
      pop_cyc.push_back(cyc);
      pop_val.push_back(bus.c_out[0][0]);
    end
  end

  initial begin
    amat_t         a;
    int            lat;
    logic [63:0]   wrap_full;
    logic [OW-1:0] wrap_exp;
    int            t;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.in_signed = 1'b0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b1;
    model_c       = '0;
    model_ovf     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_out_ovf", bus.out_ovf, 0);
    chk_mat("reset_c_out", bus.c_out, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    // A[i][j] = i+j times identity, latency measurement
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) a[i][j] = W'(i + j);
    send(a, ident(), 1'b0, 1'b0);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      lat++;
    end
    chk("latency", lat, MS + 2);
    drain();
    for (int j = 0; j < N; j++) chk("row0", bus.c_out[0][j], j);

    // signed vs unsigned interpretation of the same bits
    send(fill(16'hFFFF), fill(16'h0002), 1'b1, 1'b0);
    drain();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("signed_m8", bus.c_out[i][j], 40'hFF_FFFF_FFF8);
    send(fill(16'hFFFF), fill(16'h0002), 1'b0, 1'b0);
    drain();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("unsigned_524280", bus.c_out[i][j], 524280);

    // back-to-back accumulate 3, 6, 9
    pop_cyc.delete();
    send(ident(), fill(16'd3), 1'b0, 1'b0);
    send(ident(), fill(16'd3), 1'b0, 1'b1);
    send(ident(), fill(16'd3), 1'b0, 1'b1);
    drain();
    chk("acc_outputs", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      chk("acc_no_bubble_1", pop_cyc[1] - pop_cyc[0], 1);
      chk("acc_no_bubble_2", pop_cyc[2] - pop_cyc[1], 1);
    end
    chk("acc_final_9", bus.c_out[N-1][N-1], 9);

    // stream of 8 with a 4-cycle output stall
    pop_val.delete();
    for (int k = 0; k < 6; k++) send(fill(W'(k)), ident(), 1'b0, 1'b0);
    drive_op(fill(W'(6)), ident(), 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_accept();
    send(fill(W'(7)), ident(), 1'b0, 1'b0);
    drain();
    chk("stream_count", pop_val.size(), 8);
    if (pop_val.size() == 8)
      for (int k = 0; k < 8; k++) chk("stream_order", pop_val[k], k);

    // unsigned overflow on the 65th accumulated op
    send(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b0);
    for (int k = 0; k < 63; k++) send(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b1);
    drain();
    chk("ovf_clear_op64", bus.out_ovf, 0);
    send(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b1);
    drain();
    wrap_full = 64'd65 * 64'd4 * 64'd65535 * 64'd65535;
    wrap_exp  = wrap_full[OW-1:0];
    chk("ovf_set_op65", bus.out_ovf, 1);
    chk("ovf_wrap_value", bus.c_out[1][2], wrap_exp);
    send(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b0);
    drain();
    chk("ovf_cleared_by_fresh", bus.out_ovf, 0);

    // reset with ops in flight and a held result
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(ident(), fill(16'd1), 1'b0, 1'b0);
    t = 0;
    while (bus.out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("pre_reset_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_out_valid", bus.out_valid, 0);
    chk("mid_reset_busy", bus.busy, 0);
    chk("mid_reset_out_ovf", bus.out_ovf, 0);
    chk_mat("mid_reset_c_out", bus.c_out, '0);
    sb.delete();
    model_c   = '0;
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(ident(), fill(16'd5), 1'b0, 1'b1);
    drain();
    chk("post_reset_acc_5", bus.c_out[0][0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
